// File: rtl/sst_pkg.sv
// sst_pkg: shared types and defaults for the save-state sequencer.
//   sst_state_t      : sequencer FSM state encoding
//   SST_REG_CNT_DEF  : default number of SST register addresses walked
//   SST_IDX_ADDR_DEF : default read-only address holding the mapper index
// SST_CSUM_EN adds the two checksum states to the enum.
package sst_pkg;

    localparam int SST_REG_CNT_DEF  = 128;
    localparam int SST_IDX_ADDR_DEF = 127;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        SV_ADDR = 4'd1,
        SV_OUT  = 4'd2,
        LD_IN   = 4'd3,
        LD_WR   = 4'd4,
        LD_GAP  = 4'd5,
        DONE    = 4'd6
`ifdef SST_CSUM_EN
        ,
        SV_CSUM = 4'd7,
        LD_CSUM = 4'd8
`endif
    } sst_state_t;

endpackage

// File: rtl/sst_seq_if.sv
// sst_seq_if: groups the per-mapper SST port and the two host byte streams.
//   sst_act/sst_addr/sst_we_reg/sst_dato : sequencer -> mapper
//   sst_di                               : mapper -> sequencer (combinational read data)
//   out_valid/out_data, out_ready        : save stream (sequencer is source)
//   in_valid/in_data, in_ready           : load stream (sequencer is sink)
// master = sequencer side, slave = mapper/host side.
interface sst_seq_if;

    logic       sst_act;
    logic [7:0] sst_addr;
    logic       sst_we_reg;
    logic [7:0] sst_dato;
    logic [7:0] sst_di;

    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;

    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;

    modport master (
        output sst_act, sst_addr, sst_we_reg, sst_dato,
        output out_valid, out_data, in_ready,
        input  sst_di, out_ready, in_valid, in_data
    );

    modport slave (
        input  sst_act, sst_addr, sst_we_reg, sst_dato,
        input  out_valid, out_data, in_ready,
        output sst_di, out_ready, in_valid, in_data
    );

endinterface

// File: rtl/sst_csum.sv
// sst_csum: 8-bit modular-sum accumulator for the save-state checksum.
//   clk, map_rst : clock, synchronous active-high reset
//   clr          : restart the sum at 8'h00 (priority over add)
//   add, din     : accumulate din this cycle
//   sum          : registered running sum
// Only instantiated when SST_CSUM_EN is defined.
module sst_csum (
    input  logic       clk,
    input  logic       map_rst,
    input  logic       clr,
    input  logic       add,
    input  logic [7:0] din,
    output logic [7:0] sum
);

    logic [7:0] sum_d, sum_q;

    always_comb begin
        sum_d = sum_q;
        if (clr) begin
            sum_d = 8'h00;
        end else if (add) begin
            sum_d = sum_q + din;
        end
    end

    always_ff @(posedge clk) begin
        if (map_rst) begin
            sum_q <= 8'h00;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;

endmodule

// File: rtl/sst_seq.sv
// sst_seq: save-state sequencer for the mapper register file.
// Save walks addresses 0..REG_CNT-1, reads each byte over the SST bus and
// streams it to the host; load takes a host byte stream and writes each byte
// back through sst_we_reg, checking (not writing) the mapper index address.
//   clk, map_rst             : clock, synchronous active-high reset
//   start_save, start_load   : one-cycle requests, honoured only in IDLE
//   busy, done, map_mismatch : status (map_mismatch sticky until next start)
//   csum_err                 : only with SST_CSUM_EN, sticky checksum error
//   sst                      : sst_seq_if.master (SST bus + both streams)
// Build macro: SST_CSUM_EN appends a mod-256 checksum byte to save/load.
module sst_seq
    import sst_pkg::*;
#(
    parameter int REG_CNT  = SST_REG_CNT_DEF,
    parameter int IDX_ADDR = SST_IDX_ADDR_DEF
) (
    input  logic       clk,
    input  logic       map_rst,
    input  logic       start_save,
    input  logic       start_load,
    output logic       busy,
    output logic       done,
    output logic       map_mismatch,
`ifdef SST_CSUM_EN
    output logic       csum_err,
`endif
    sst_seq_if.master  sst
);

    // Last address is found by compare so REG_CNT=256 never relies on wrap.
    localparam logic [7:0] LAST_ADDR = 8'(REG_CNT - 1);
    localparam logic [7:0] IDX_A     = 8'(IDX_ADDR);

    sst_state_t state_d, state_q;
    logic [7:0] addr_d, addr_q;
    logic [7:0] dato_d, dato_q;
    logic [7:0] out_data_d, out_data_q;
    logic       we_d, we_q;
    logic       busy_d, busy_q;
    logic       done_d, done_q;
    logic       mism_d, mism_q;
    logic       out_valid_d, out_valid_q;
    logic       in_ready_d, in_ready_q;
    logic       start_any;

    assign start_any = (state_q == IDLE) && (start_save || start_load);

`ifdef SST_CSUM_EN
    logic       csum_err_d, csum_err_q;
    logic       csum_add;
    logic [7:0] csum_din;
    logic [7:0] csum_sum;

    // Save bytes are summed as they are captured, load bytes on handshake,
    // so the sum is complete by the time the checksum byte is due.
    always_comb begin
        csum_add = 1'b0;
        csum_din = sst.sst_di;
        if (state_q == SV_ADDR) begin
            csum_add = 1'b1;
        end else if ((state_q == LD_IN) && sst.in_valid) begin
            csum_add = 1'b1;
            csum_din = sst.in_data;
        end
    end

    sst_csum u_csum (
        .clk     (clk),
        .map_rst (map_rst),
        .clr     (start_any),
        .add     (csum_add),
        .din     (csum_din),
        .sum     (csum_sum)
    );
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        dato_d      = dato_q;
        out_data_d  = out_data_q;
        we_d        = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        mism_d      = mism_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
`ifdef SST_CSUM_EN
        csum_err_d  = csum_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_any) begin
                    addr_d = 8'h00;
                    busy_d = 1'b1;
                    mism_d = 1'b0;
`ifdef SST_CSUM_EN
                    csum_err_d = 1'b0;
`endif
                    if (start_save) begin
                        state_d = SV_ADDR;
                    end else begin
                        state_d    = LD_IN;
                        in_ready_d = 1'b1;
                    end
                end
            end
            SV_ADDR: begin
                // Address has settled for a full cycle; capture read data.
                state_d     = SV_OUT;
                out_valid_d = 1'b1;
                out_data_d  = sst.sst_di;
            end
            SV_OUT: begin
                if (sst.out_ready) begin
                    out_valid_d = 1'b0;
                    if (addr_q == LAST_ADDR) begin
`ifdef SST_CSUM_EN
                        state_d     = SV_CSUM;
                        out_valid_d = 1'b1;
                        out_data_d  = csum_sum;
`else
                        state_d = DONE;
                        done_d  = 1'b1;
`endif
                    end else begin
                        addr_d  = addr_q + 8'd1;
                        state_d = SV_ADDR;
                    end
                end
            end
            LD_IN: begin
                if (sst.in_valid) begin
                    in_ready_d = 1'b0;
                    dato_d     = sst.in_data;
                    state_d    = LD_WR;
                    // The index address is read-only: verify instead of write.
                    we_d       = (addr_q != IDX_A);
                end
            end
            LD_WR: begin
                if ((addr_q == IDX_A) && (dato_q != sst.sst_di)) begin
                    mism_d = 1'b1;
                end
                state_d = LD_GAP;
            end
            LD_GAP: begin
                if (addr_q == LAST_ADDR) begin
`ifdef SST_CSUM_EN
                    state_d    = LD_CSUM;
                    in_ready_d = 1'b1;
`else
                    state_d = DONE;
                    done_d  = 1'b1;
`endif
                end else begin
                    addr_d     = addr_q + 8'd1;
                    state_d    = LD_IN;
                    in_ready_d = 1'b1;
                end
            end
`ifdef SST_CSUM_EN
            SV_CSUM: begin
                if (sst.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = DONE;
                    done_d      = 1'b1;
                end
            end
            LD_CSUM: begin
                if (sst.in_valid) begin
                    in_ready_d = 1'b0;
                    if (sst.in_data != csum_sum) begin
                        csum_err_d = 1'b1;
                    end
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                addr_d  = 8'h00;
                dato_d  = 8'h00;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (map_rst) begin
            state_q     <= IDLE;
            addr_q      <= 8'h00;
            dato_q      <= 8'h00;
            out_data_q  <= 8'h00;
            we_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mism_q      <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
`ifdef SST_CSUM_EN
            csum_err_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            dato_q      <= dato_d;
            out_data_q  <= out_data_d;
            we_q        <= we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mism_q      <= mism_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
`ifdef SST_CSUM_EN
            csum_err_q  <= csum_err_d;
`endif
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign map_mismatch   = mism_q;
`ifdef SST_CSUM_EN
    assign csum_err       = csum_err_q;
`endif
    assign sst.sst_act    = busy_q;
    assign sst.sst_addr   = addr_q;
    assign sst.sst_we_reg = we_q;
    assign sst.sst_dato   = dato_q;
    assign sst.out_valid  = out_valid_q;
    assign sst.out_data   = out_data_q;
    assign sst.in_ready   = in_ready_q;

endmodule
